// File: rtl/score_ctrl_mc_pkg.sv
// Shared definitions for the multi-channel score controller: game status codes,
// converter states and a constant-width helper.
package score_pkg;

    localparam logic [1:0] ST_RESTART = 2'b00;
    localparam logic [1:0] ST_PLAY    = 2'b01;
    localparam logic [1:0] ST_PAUSE   = 2'b10;
    localparam logic [1:0] ST_OVER    = 2'b11;

    typedef enum logic [1:0] {
        CV_IDLE,
        CV_LOAD,
        CV_SHIFT,
        CV_STORE
    } conv_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/score_ctrl_mc_bin2bcd.sv
// Sequential double-dabble engine: one add-3/shift step per cycle, with the first
// step taken on the start cycle so the result is ready SCORE_W cycles after start.
module bin2bcd_seq
    import score_pkg::*;
#(
    parameter int SCORE_W = 8,
    parameter int DIGITS  = 3
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [SCORE_W-1:0]    bin,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int BCD_W = DIGITS * 4;
    localparam int CNT_W = clog2(SCORE_W + 1);

    logic [SCORE_W-1:0] sh;
    logic [CNT_W-1:0]   cnt;

    function automatic logic [BCD_W+SCORE_W-1:0] dd_step(input logic [BCD_W-1:0]   acc,
                                                         input logic [SCORE_W-1:0] src);
        logic [BCD_W-1:0] adj;
        adj = acc;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[d*4 +: 4] >= 4'd5) adj[d*4 +: 4] = adj[d*4 +: 4] + 4'd3;
        end
        return {adj, src} << 1;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh   <= '0;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            bcd  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                {bcd, sh} <= dd_step('0, bin);
                cnt       <= CNT_W'(SCORE_W - 1);
                busy      <= (SCORE_W > 1);
                done      <= (SCORE_W == 1);
            end else if (busy) begin
                {bcd, sh} <= dd_step(bcd, sh);
                cnt       <= cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/score_ctrl_mc.sv
// Multi-channel score accumulator with best-score tracking and a shared BCD sweep.
// Optional combo scoring is compiled in with SCORE_COMBO_EN.
//
// state    | meaning
// CV_IDLE  | just out of reset, moves to LOAD next cycle
// CV_LOAD  | starts the engine on the value selected by conv_idx
// CV_SHIFT | engine iterating, waits for done
// CV_STORE | writes result to the selected bcd register, advances conv_idx
module score_ctrl_mc
    import score_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int SCORE_W   = 8,
    parameter int PTS_W     = 3,
    parameter int MAX_SCORE = 100,
    parameter int DIGITS    = 3,
    parameter int COMBO_WIN = 64,
    localparam int CH_W     = (NCH > 1) ? clog2(NCH) : 1
)(
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NCH-1:0]             add_evt,
    input  logic [NCH*PTS_W-1:0]       add_pts,
    input  logic [1:0]                 game_status,
    output logic [NCH*SCORE_W-1:0]     score_bin,
    output logic [SCORE_W-1:0]         best_bin,
    output logic [CH_W-1:0]            best_ch,
    output logic                       new_record,
    output logic [NCH*DIGITS*4-1:0]    bcd_score,
    output logic [DIGITS*4-1:0]        bcd_best,
    output logic                       bcd_valid
);

    localparam int IDX_W = clog2(NCH + 1);
    localparam int BCD_W = DIGITS * 4;
    localparam int SUM_W = SCORE_W + 1;
    localparam logic [SUM_W-1:0] MAX_SUM = SUM_W'(MAX_SCORE);

    logic [SCORE_W-1:0] score   [NCH];
    logic [SUM_W-1:0]   pts_eff [NCH];

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] s,
                                                   input logic [SUM_W-1:0]   p);
        logic [SUM_W-1:0] sum;
        sum = {1'b0, s} + p;
        return (sum > MAX_SUM) ? MAX_SUM[SCORE_W-1:0] : sum[SCORE_W-1:0];
    endfunction

`ifdef SCORE_COMBO_EN
    localparam int CMB_W = clog2(COMBO_WIN + 1);
    logic [CMB_W-1:0] combo_cnt [NCH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) combo_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (game_status)
                    ST_RESTART: combo_cnt[i] <= '0;
                    ST_PLAY: begin
                        if (add_evt[i])              combo_cnt[i] <= CMB_W'(COMBO_WIN);
                        else if (combo_cnt[i] != '0) combo_cnt[i] <= combo_cnt[i] - 1'b1;
                    end
                    ST_PAUSE: combo_cnt[i] <= combo_cnt[i];
                    ST_OVER: begin
                        if (combo_cnt[i] != '0) combo_cnt[i] <= combo_cnt[i] - 1'b1;
                    end
                endcase
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            pts_eff[i] = SUM_W'(add_pts[i*PTS_W +: PTS_W]);
            if (combo_cnt[i] != '0) pts_eff[i] = pts_eff[i] << 1;
        end
    end
`else
    // Window length only matters when combo scoring is compiled in.
    logic unused_combo_win;
    assign unused_combo_win = (COMBO_WIN > 0);

    always_comb begin
        for (int i = 0; i < NCH; i++) pts_eff[i] = SUM_W'(add_pts[i*PTS_W +: PTS_W]);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) score[i] <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                case (game_status)
                    ST_RESTART: score[i] <= '0;
                    ST_PLAY:    if (add_evt[i]) score[i] <= sat_add(score[i], pts_eff[i]);
                    ST_PAUSE,
                    ST_OVER:    score[i] <= score[i];
                endcase
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_score_out
        assign score_bin[g*SCORE_W +: SCORE_W] = score[g];
    end

    // Strict compare keeps the lowest channel on ties.
    logic [SCORE_W-1:0] top_val;
    logic [CH_W-1:0]    top_ch;

    always_comb begin
        top_val = '0;
        top_ch  = '0;
        for (int i = 0; i < NCH; i++) begin
            if (score[i] > top_val) begin
                top_val = score[i];
                top_ch  = CH_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            best_bin   <= '0;
            best_ch    <= '0;
            new_record <= 1'b0;
        end else begin
            new_record <= 1'b0;
            if (top_val > best_bin) begin
                best_bin   <= top_val;
                best_ch    <= top_ch;
                new_record <= 1'b1;
            end
        end
    end

    conv_state_t        cv_state;
    logic [IDX_W-1:0]   conv_idx;
    logic               conv_start;
    logic               conv_busy;
    logic               conv_done;
    logic [SCORE_W-1:0] conv_bin;
    logic [BCD_W-1:0]   conv_bcd;

    assign conv_start = (cv_state == CV_LOAD);

    always_comb begin
        conv_bin = best_bin;
        for (int i = 0; i < NCH; i++) begin
            if (conv_idx == IDX_W'(i)) conv_bin = score[i];
        end
    end

    bin2bcd_seq #(
        .SCORE_W (SCORE_W),
        .DIGITS  (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .start (conv_start),
        .bin   (conv_bin),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cv_state  <= CV_IDLE;
            conv_idx  <= '0;
            bcd_score <= '0;
            bcd_best  <= '0;
            bcd_valid <= 1'b0;
        end else if (game_status == ST_RESTART) begin
            cv_state  <= CV_LOAD;
            conv_idx  <= '0;
            bcd_score <= '0;
        end else begin
            case (cv_state)
                CV_IDLE:  cv_state <= CV_LOAD;
                CV_LOAD:  cv_state <= CV_SHIFT;
                CV_SHIFT: begin
                    if (conv_done)      cv_state <= CV_STORE;
                    else if (!conv_busy) cv_state <= CV_LOAD;
                end
                CV_STORE: begin
                    if (conv_idx == IDX_W'(NCH)) begin
                        bcd_best  <= conv_bcd;
                        bcd_valid <= 1'b1;
                        conv_idx  <= '0;
                    end else begin
                        for (int i = 0; i < NCH; i++) begin
                            if (conv_idx == IDX_W'(i)) bcd_score[i*BCD_W +: BCD_W] <= conv_bcd;
                        end
                        conv_idx <= conv_idx + 1'b1;
                    end
                    cv_state <= CV_LOAD;
                end
                default:  cv_state <= CV_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_score_ctrl_mc.sv
// Directed bench for score_ctrl_mc with NCH=2, SCORE_W=8, MAX_SCORE=100, DIGITS=3.
module tb_score_ctrl_mc;
    import score_pkg::*;

    localparam int COMBO_WIN = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  add_evt = '0;
    logic [5:0]  add_pts = '0;
    logic [1:0]  game_status = ST_PAUSE;
    logic [15:0] score_bin;
    logic [7:0]  best_bin;
    logic [0:0]  best_ch;
    logic        new_record;
    logic [23:0] bcd_score;
    logic [11:0] bcd_best;
    logic        bcd_valid;

    int errors = 0;
    int checks = 0;
    int rec_cnt = 0;

    score_ctrl_mc #(
        .NCH(2), .SCORE_W(8), .PTS_W(3), .MAX_SCORE(100), .DIGITS(3), .COMBO_WIN(COMBO_WIN)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .add_evt     (add_evt),
        .add_pts     (add_pts),
        .game_status (game_status),
        .score_bin   (score_bin),
        .best_bin    (best_bin),
        .best_ch     (best_ch),
        .new_record  (new_record),
        .bcd_score   (bcd_score),
        .bcd_best    (bcd_best),
        .bcd_valid   (bcd_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (new_record === 1'b1) rec_cnt = rec_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        game_status = ST_PAUSE;
        tick(3);
        checks++;
        if ({score_bin, best_bin, best_ch, new_record} !== 26'h0) begin
            errors++;
            $display("FAIL reset_bin: got %h expected 0", {score_bin, best_bin, best_ch, new_record});
        end
        checks++;
        if ({bcd_score, bcd_best} !== 36'h0) begin
            errors++;
            $display("FAIL reset_bcd: got %h expected 0", {bcd_score, bcd_best});
        end
        checks++;
        if (bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: got %b expected 0", bcd_valid);
        end
    endtask

    task automatic test_single_channel();
        rst = 1'b0;
        game_status = ST_PLAY;
        rec_cnt = 0;
        add_pts = {3'd0, 3'd5};
        add_evt = 2'b01;
        tick(3);
        add_evt = 2'b00;
        checks++;
        if (score_bin !== {8'd0, 8'd15}) begin
            errors++;
            $display("FAIL single_score: got %h expected %h", score_bin, {8'd0, 8'd15});
        end
        tick(62);
        checks++;
        if (bcd_score !== 24'h000015) begin
            errors++;
            $display("FAIL single_bcd_score: got %h expected 000015", bcd_score);
        end
        checks++;
        if ({bcd_best, best_bin, best_ch} !== {12'h015, 8'd15, 1'b0}) begin
            errors++;
            $display("FAIL single_best: got %h/%0d/%0d expected 015/15/0", bcd_best, best_bin, best_ch);
        end
        checks++;
        if (rec_cnt !== 3) begin
            errors++;
            $display("FAIL single_record_pulses: got %0d expected 3", rec_cnt);
        end
        checks++;
        if (bcd_valid !== 1'b1) begin
            errors++;
            $display("FAIL single_valid: got %b expected 1", bcd_valid);
        end
    endtask

    task automatic test_simultaneous();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        rec_cnt = 0;
        game_status = ST_PLAY;
        add_evt = 2'b11;
        add_pts = {3'd5, 3'd5};
        tick(2);
        add_pts = {3'd4, 3'd4};
        tick(1);
        add_evt = 2'b00;
        tick(1);
        checks++;
        if (score_bin !== {8'd14, 8'd14}) begin
            errors++;
            $display("FAIL simul_score: got %h expected %h", score_bin, {8'd14, 8'd14});
        end
        checks++;
        if ({best_bin, best_ch} !== {8'd14, 1'b0}) begin
            errors++;
            $display("FAIL simul_best: got %0d/%0d expected 14/0", best_bin, best_ch);
        end
        add_evt = 2'b10;
        add_pts = {3'd1, 3'd0};
        tick(1);
        add_evt = 2'b00;
        tick(1);
        checks++;
        if ({best_bin, best_ch} !== {8'd15, 1'b1}) begin
            errors++;
            $display("FAIL simul_best_ch1: got %0d/%0d expected 15/1", best_bin, best_ch);
        end
        add_evt = 2'b01;
        add_pts = {3'd0, 3'd1};
        tick(1);
        add_evt = 2'b00;
        tick(1);
        checks++;
        if ({score_bin, best_ch} !== {8'd15, 8'd15, 1'b1}) begin
            errors++;
            $display("FAIL simul_equal_keeps_ch: got %h/%0d expected 0f0f/1", score_bin, best_ch);
        end
        checks++;
        if (rec_cnt !== 4) begin
            errors++;
            $display("FAIL simul_record_pulses: got %0d expected 4", rec_cnt);
        end
        tick(62);
        checks++;
        if ({bcd_score, bcd_best} !== {12'h015, 12'h015, 12'h015}) begin
            errors++;
            $display("FAIL simul_bcd: got %h/%h expected 015015/015", bcd_score, bcd_best);
        end
    endtask

    task automatic test_saturation();
        game_status = ST_RESTART;
        tick(1);
        game_status = ST_PLAY;
        add_evt = 2'b01;
        add_pts = {3'd0, 3'd7};
        tick(14);
        add_evt = 2'b00;
        checks++;
        if (score_bin[7:0] !== 8'd98) begin
            errors++;
            $display("FAIL sat_98: got %0d expected 98", score_bin[7:0]);
        end
        add_evt = 2'b01;
        tick(1);
        checks++;
        if (score_bin[7:0] !== 8'd100) begin
            errors++;
            $display("FAIL sat_clip: got %0d expected 100", score_bin[7:0]);
        end
        tick(1);
        add_pts = {3'd0, 3'd0};
        tick(1);
        add_evt = 2'b00;
        checks++;
        if (score_bin !== {8'd0, 8'd100}) begin
            errors++;
            $display("FAIL sat_hold: got %h expected %h", score_bin, {8'd0, 8'd100});
        end
        tick(62);
        checks++;
        if ({bcd_score, bcd_best} !== {12'h000, 12'h100, 12'h100}) begin
            errors++;
            $display("FAIL sat_bcd: got %h/%h expected 000100/100", bcd_score, bcd_best);
        end
        checks++;
        if ({best_bin, best_ch} !== {8'd100, 1'b0}) begin
            errors++;
            $display("FAIL sat_best: got %0d/%0d expected 100/0", best_bin, best_ch);
        end
    endtask

    task automatic test_restart_pause();
        game_status = ST_PLAY;
        add_evt = 2'b10;
        add_pts = {3'd6, 3'd0};
        tick(1);
        add_evt = 2'b00;
        checks++;
        if (score_bin !== {8'd6, 8'd100}) begin
            errors++;
            $display("FAIL rp_pre: got %h expected %h", score_bin, {8'd6, 8'd100});
        end
        game_status = ST_RESTART;
        tick(1);
        checks++;
        if ({score_bin, bcd_score} !== 40'h0) begin
            errors++;
            $display("FAIL rp_clear: got %h/%h expected 0/0", score_bin, bcd_score);
        end
        checks++;
        if ({best_bin, bcd_best, bcd_valid} !== {8'd100, 12'h100, 1'b1}) begin
            errors++;
            $display("FAIL rp_best_kept: got %0d/%h/%b expected 100/100/1", best_bin, bcd_best, bcd_valid);
        end
        game_status = ST_PAUSE;
        add_evt = 2'b11;
        add_pts = {3'd5, 3'd5};
        tick(3);
        game_status = ST_OVER;
        tick(3);
        add_evt = 2'b00;
        checks++;
        if (score_bin !== 16'h0) begin
            errors++;
            $display("FAIL rp_ignore: got %h expected 0", score_bin);
        end
        tick(62);
        checks++;
        if ({bcd_score, bcd_best} !== {24'h0, 12'h100}) begin
            errors++;
            $display("FAIL rp_bcd: got %h/%h expected 000000/100", bcd_score, bcd_best);
        end
    endtask

    task automatic test_rst_mid_shift();
        bit found;
        int budget;
        game_status = ST_PLAY;
        add_evt = 2'b01;
        add_pts = {3'd0, 3'd5};
        tick(1);
        add_evt = 2'b00;
        found = 1'b0;
        budget = 0;
        while (!found && budget < 40) begin
            if (dut.cv_state == CV_SHIFT) found = 1'b1;
            else begin
                tick(1);
                budget++;
            end
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL mid_shift_reach: got no SHIFT within %0d cycles expected SHIFT", budget);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({score_bin, best_bin, best_ch, new_record} !== 26'h0) begin
            errors++;
            $display("FAIL mid_rst_bin: got %h expected 0", {score_bin, best_bin, best_ch, new_record});
        end
        checks++;
        if ({bcd_score, bcd_best, bcd_valid} !== 37'h0) begin
            errors++;
            $display("FAIL mid_rst_bcd: got %h expected 0", {bcd_score, bcd_best, bcd_valid});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        game_status = ST_PAUSE;
        tick(30);
        checks++;
        if (bcd_valid !== 1'b0) begin
            errors++;
            $display("FAIL valid_early: got %b expected 0 after 30 cycles", bcd_valid);
        end
        tick(1);
        checks++;
        if (bcd_valid !== 1'b1) begin
            errors++;
            $display("FAIL valid_on_time: got %b expected 1 after 31 cycles", bcd_valid);
        end
    endtask

    task automatic test_combo();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        game_status = ST_PLAY;
        add_pts = {3'd3, 3'd0};
        add_evt = 2'b10;
        tick(1);
        add_evt = 2'b00;
        tick(9);
        add_evt = 2'b10;
        tick(1);
        add_evt = 2'b00;
        checks++;
`ifdef SCORE_COMBO_EN
        if (score_bin[15:8] !== 8'd9) begin
            errors++;
            $display("FAIL combo_second: got %0d expected 9", score_bin[15:8]);
        end
`else
        if (score_bin[15:8] !== 8'd6) begin
            errors++;
            $display("FAIL combo_second: got %0d expected 6", score_bin[15:8]);
        end
`endif
        tick(COMBO_WIN + 4);
        add_evt = 2'b10;
        tick(1);
        add_evt = 2'b00;
        checks++;
`ifdef SCORE_COMBO_EN
        if (score_bin[15:8] !== 8'd12) begin
            errors++;
            $display("FAIL combo_expired: got %0d expected 12", score_bin[15:8]);
        end
`else
        if (score_bin[15:8] !== 8'd9) begin
            errors++;
            $display("FAIL combo_expired: got %0d expected 9", score_bin[15:8]);
        end
`endif
        game_status = ST_PAUSE;
        tick(100);
        game_status = ST_PLAY;
        add_evt = 2'b10;
        tick(1);
        add_evt = 2'b00;
        checks++;
`ifdef SCORE_COMBO_EN
        if (score_bin[15:8] !== 8'd18) begin
            errors++;
            $display("FAIL combo_pause_freeze: got %0d expected 18", score_bin[15:8]);
        end
`else
        if (score_bin[15:8] !== 8'd12) begin
            errors++;
            $display("FAIL combo_pause_freeze: got %0d expected 12", score_bin[15:8]);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_single_channel();
        test_simultaneous();
        test_saturation();
        test_restart_pause();
        test_rst_mid_shift();
        test_combo();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_ctrl_mc.md
Name: score_ctrl_mc

Overview:
Multi-channel, parametrised successor to the single-player score counter. Accumulates a weighted score per player channel and tracks the all-time best score with its owning channel. Converts every score to BCD through one shared sequential double-dabble engine, and flags new records. Sits between the game FSM (collision/food events, game_status) and the seven-segment/VGA score display.

Parameters:
NCH, 2, number of player channels (1..4)
SCORE_W, 8, binary score width per channel
PTS_W, 3, width of per-event points input
MAX_SCORE, 100, saturation ceiling; must be < 2^SCORE_W
DIGITS, 3, BCD digits per value; 10^DIGITS > MAX_SCORE required
COMBO_WIN, 64, combo window in cycles (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
add_evt  in  NCH  per-channel score event, one-cycle pulse
add_pts  in  NCH*PTS_W  points for each channel's event; channel i in bits [i*PTS_W +: PTS_W]
game_status  in  2  00 RESTART, 01 PLAY, 10 PAUSE, 11 OVER
score_bin  out  NCH*SCORE_W  current binary scores
best_bin  out  SCORE_W  best score since reset
best_ch  out  clog2(NCH) or 1  channel that set best_bin
new_record  out  1  one-cycle pulse when best_bin increases
bcd_score  out  NCH*DIGITS*4  BCD of each score; channel i in bits [i*DIGITS*4 +: DIGITS*4]
bcd_best  out  DIGITS*4  BCD of best_bin
bcd_valid  out  1  high once every BCD output holds a converted value

Behaviour:
- Reset (async, rst=1): all scores, best_bin, best_ch, bcd_* and bcd_valid go to 0; new_record is 0; converter FSM goes to IDLE. Reset takes effect immediately, including mid-conversion.
- RESTART: scores cleared to 0 on the next edge. best_bin and best_ch are kept; only rst clears them.
- RESTART also aborts any in-flight conversion. It zeroes bcd_score on the same edge and restarts the sweep at channel 0. bcd_valid is unchanged.
- PLAY: when add_evt[i]=1, score[i] <= min(score[i] + add_pts[i], MAX_SCORE). The sum is computed SCORE_W+1 bits wide. add_pts=0 leaves the score unchanged.
- PAUSE/OVER: add_evt is ignored; scores hold.
- Channels update independently. Simultaneous events on all channels are all applied in the same cycle.
- Best tracking is registered, one cycle after the score update. If any score[i] > best_bin (strict), then best_bin <= max score and best_ch <= lowest index holding that max.
- Equal-to-best does not change best_ch.
- new_record pulses high for exactly the cycle in which best_bin changes.
- Converter FSM (IDLE -> LOAD -> SHIFT -> STORE -> LOAD ...):
  - IDLE: leaves after reset on the first cycle.
  - LOAD: snapshots the selected value, sequencing ch0..ch(NCH-1), then best.
  - SHIFT: runs SCORE_W add-3/shift iterations, one per cycle.
  - STORE: writes the selected bcd register, then advances the index with wrap.
- Per-value latency is SCORE_W+2 cycles. A full sweep takes (NCH+1)*(SCORE_W+2) cycles.
- bcd_valid goes to 1 at the STORE that completes the first full sweep after rst. It stays 1 until the next rst.
- Any value change appears on the bcd outputs within 2 sweeps.
- The converter runs continuously in all game states.

Optional Feature:
SCORE_COMBO_EN
- Defined: each channel has a counter loaded with COMBO_WIN on every accepted add_evt, decrementing to 0.
  - An add_evt arriving while that channel's counter is nonzero scores 2*add_pts, still saturating at MAX_SCORE.
  - Counters clear on rst and on RESTART, and freeze in PAUSE.
- Undefined: no counters; points are always add_pts.

Decomposition:
- Package score_pkg holds:
  - status encodings ST_RESTART, ST_PLAY, ST_PAUSE, ST_OVER;
  - converter FSM state enum;
  - clog2 helper function.
- Sub-module bin2bcd_seq (parametrised SCORE_W, DIGITS) holds the shared double-dabble engine:
  - inputs start and bin; outputs busy, done and bcd.
  - the top level owns the sequencing index and the BCD output registers.

Test Plan (NCH=2, SCORE_W=8, MAX_SCORE=100, DIGITS=3):
1. rst high, then low, PLAY; ch0 three events pts=5 -> score_bin ch0=15. After 2 sweeps: bcd_score ch0=12'h015, bcd_best=12'h015, best_ch=0, new_record pulsed 3 times.
2. ch0 at 98, event pts=7 -> score ch0=100 (saturates); further events keep 100; bcd=12'h100.
3. Same cycle, ch0 +4 and ch1 +4 from 10/10 -> both 14; best_bin=14, best_ch=0.
4. RESTART after best=100 -> scores 0 next edge; bcd_score zeroed; best_bin stays 100 with bcd_best 12'h100; events ignored while in PAUSE.
5. Assert rst during the SHIFT state -> all outputs 0 immediately. bcd_valid low until (NCH+1)*(SCORE_W+2)+1 cycles after release.
6. With SCORE_COMBO_EN: two ch1 events pts=3, 10 cycles apart -> score 9. A third event COMBO_WIN+5 cycles later -> 12.
